// File: rtl/axis_dwa_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_dwa_encoder_if
//  Purpose  : Minimal AXI-Stream channel (tdata/tvalid/tready) used for the
//             input and output streams of the DWA encoder.
//  Params   : W - tdata width
//  Signals  : tdata  - payload
//             tvalid - source has a beat
//             tready - sink can take the beat
//  Modports : master (drives tdata/tvalid), slave (drives tready)
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_dwa_encoder_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_dwa_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : axis_dwa_encoder
//  Purpose  : Converts the signed multi-level code of a MASH 1-1 modulator
//             into a unit-element enable vector for an N_ELEM element DAC.
//             The code is offset and saturated to an element count, then
//             either a fixed thermometer code or a data-weighted-averaging
//             (rotating) selection is produced. Registered AXI-Stream output
//             with backpressure.
//  Ports    : aclk        - clock
//             arst_n      - synchronous active-low reset
//             s_axis_data - input stream, signed code (DAC_BW bits)
//             m_axis_data - output stream, element enables (N_ELEM bits)
//             dwa_en      - 1 = rotate selection, 0 = fixed thermometer
//             sat_clear   - synchronous clear of sat_count
//             ptr         - current rotation pointer
//             sat_count   - number of accepted samples that were clamped
//  Revision : 1.0 - initial release
// ============================================================================
module axis_dwa_encoder #(
    parameter  int DAC_BW = 4,
    parameter  int N_ELEM = 3,
    parameter  int OFFSET = 1,
    parameter  int CNT_W  = 16,
    localparam int PTR_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  wire logic              aclk,
    input  wire logic              arst_n,
    axis_dwa_encoder_if.slave      s_axis_data,
    axis_dwa_encoder_if.master     m_axis_data,
    input  wire logic              dwa_en,
    input  wire logic              sat_clear,
    output logic [PTR_W-1:0]       ptr,
    output logic [CNT_W-1:0]       sat_count
);

    localparam int RAW_W = DAC_BW + 2;
    localparam int LVL_W = $clog2(N_ELEM + 1);

    localparam logic signed [RAW_W-1:0] OFFSET_S = RAW_W'(OFFSET);
    localparam logic        [CNT_W-1:0] CNT_MAX  = '1;

    logic [N_ELEM-1:0]        out_data;
    logic                     out_valid;

    logic                     in_ready;
    logic                     accept;

    logic signed [RAW_W-1:0]  raw;
    int                       raw_i;
    logic [LVL_W-1:0]         level;
    logic                     clamped;
    logic [N_ELEM-1:0]        mask;
    logic [2*N_ELEM-1:0]      mask_dbl;
    logic [N_ELEM-1:0]        rotated;
    int                       ptr_sum;
    logic [PTR_W-1:0]         ptr_next;
    logic [N_ELEM-1:0]        enc_next;

    // ------------------------------------------------------------------
    // Handshake: the single output register can take a new beat when it
    // is empty or being drained this cycle.
    // ------------------------------------------------------------------
    assign in_ready           = arst_n & (~out_valid | m_axis_data.tready);
    assign accept             = s_axis_data.tvalid & in_ready;
    assign s_axis_data.tready = in_ready;
    assign m_axis_data.tdata  = out_data;
    assign m_axis_data.tvalid = out_valid;

    // ------------------------------------------------------------------
    // Level, mask, rotation and next pointer
    // ------------------------------------------------------------------
    always_comb begin
        raw      = '0;
        raw_i    = 0;
        level    = '0;
        clamped  = 1'b0;
        mask     = '0;
        mask_dbl = '0;
        rotated  = '0;
        ptr_sum  = 0;
        ptr_next = '0;
        enc_next = '0;

        // Two guard bits so the offset add can never overflow.
        raw   = $signed({{2{s_axis_data.tdata[DAC_BW-1]}}, s_axis_data.tdata}) + OFFSET_S;
        raw_i = int'(raw);

        if (raw_i < 0) begin
            level   = '0;
            clamped = 1'b1;
        end else if (raw_i > N_ELEM) begin
            level   = LVL_W'(N_ELEM);
            clamped = 1'b1;
        end else begin
            level   = LVL_W'(raw_i);
        end

        // Plain thermometer: the lowest L elements.
        for (int i = 0; i < N_ELEM; i++) begin
            mask[i] = (i < int'(level));
        end

        // Rotate left by ptr modulo N_ELEM: shift a zero-padded copy and
        // fold the bits that spilled past the top back onto the bottom.
        mask_dbl = {{N_ELEM{1'b0}}, mask} << ptr;
        rotated  = mask_dbl[N_ELEM-1:0] | mask_dbl[2*N_ELEM-1:N_ELEM];

        // ptr < N_ELEM and level <= N_ELEM, so one subtraction suffices.
        ptr_sum = int'(ptr) + int'(level);
        if (ptr_sum >= N_ELEM) begin
            ptr_sum = ptr_sum - N_ELEM;
        end

        if (dwa_en) begin
            enc_next = rotated;
            ptr_next = PTR_W'(ptr_sum);
        end else begin
            enc_next = mask;
            ptr_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output register and rotation pointer
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_data  <= enc_next;
                out_valid <= 1'b1;
                ptr       <= ptr_next;
            end else if (m_axis_data.tready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturation event counter: sticks at all-ones; a clear that coincides
    // with a clamped accept still records that one event.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= (accept && clamped) ? CNT_W'(1) : '0;
        end else if (accept && clamped && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_dwa_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_dwa_encoder
//  Purpose  : Directed self-checking bench for axis_dwa_encoder with default
//             parameters, plus a second instance with a 2-bit counter that
//             shares the same stimulus to exercise counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_dwa_encoder;

    logic aclk;
    logic arst_n;
    logic dwa_en;
    logic sat_clear;
    logic [1:0]  ptr;
    logic [15:0] sat_count;
    logic [1:0]  ptr2;
    logic [1:0]  sat_count2;

    int n_checks;
    int n_errors;

    axis_dwa_encoder_if #(.W(4)) s_if ();
    axis_dwa_encoder_if #(.W(3)) m_if ();
    axis_dwa_encoder_if #(.W(4)) s2_if ();
    axis_dwa_encoder_if #(.W(3)) m2_if ();

    assign s2_if.tdata  = s_if.tdata;
    assign s2_if.tvalid = s_if.tvalid;
    assign m2_if.tready = m_if.tready;

    axis_dwa_encoder #(
        .DAC_BW (4), .N_ELEM (3), .OFFSET (1), .CNT_W (16)
    ) dut (
        .aclk        (aclk),
        .arst_n      (arst_n),
        .s_axis_data (s_if),
        .m_axis_data (m_if),
        .dwa_en      (dwa_en),
        .sat_clear   (sat_clear),
        .ptr         (ptr),
        .sat_count   (sat_count)
    );

    axis_dwa_encoder #(
        .DAC_BW (4), .N_ELEM (3), .OFFSET (1), .CNT_W (2)
    ) dut_small (
        .aclk        (aclk),
        .arst_n      (arst_n),
        .s_axis_data (s2_if),
        .m_axis_data (m2_if),
        .dwa_en      (dwa_en),
        .sat_clear   (sat_clear),
        .ptr         (ptr2),
        .sat_count   (sat_count2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic offer(input logic [3:0] code);
        s_if.tvalid = 1'b1;
        s_if.tdata  = code;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] data, input logic [1:0] p);
        check_eq({tag, ".valid"}, 32'(m_if.tvalid), 32'd1);
        check_eq({tag, ".data"},  32'(m_if.tdata),  32'(data));
        check_eq({tag, ".ptr"},   32'(ptr),         32'(p));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        arst_n       = 1'b0;
        dwa_en       = 1'b1;
        sat_clear    = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = 4'h0;
        m_if.tready  = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_eq("rst.s_ready", 32'(s_if.tready), 32'd0);
        check_eq("rst.m_valid", 32'(m_if.tvalid), 32'd0);
        check_eq("rst.m_data",  32'(m_if.tdata),  32'd0);
        check_eq("rst.ptr",     32'(ptr),         32'd0);
        check_eq("rst.sat",     32'(sat_count),   32'd0);
        arst_n = 1'b1;
        #1;
        check_eq("rel.s_ready", 32'(s_if.tready), 32'd1);

        // ---------------- DWA rotation, L=1 each ----------------
        offer(4'h0); tick(); expect_out("dwa0", 3'b001, 2'd1);
        tick();              expect_out("dwa1", 3'b010, 2'd2);
        tick();              expect_out("dwa2", 3'b100, 2'd0);
        tick();              expect_out("dwa3", 3'b001, 2'd1);
        tick();              expect_out("dwa4", 3'b010, 2'd2);

        // ---------------- wrap, full, empty from ptr=2 ----------------
        offer(4'h1); tick(); expect_out("wrap", 3'b101, 2'd1);
        offer(4'h2); tick(); expect_out("full", 3'b111, 2'd1);
        offer(4'hF); tick(); expect_out("zero", 3'b000, 2'd1);

        // ---------------- saturation counter ----------------
        offer(4'h5); tick(); expect_out("sat_hi", 3'b111, 2'd1);
        offer(4'hC); tick(); expect_out("sat_lo", 3'b000, 2'd1);
        check_eq("sat.two", 32'(sat_count), 32'd2);
        sat_clear = 1'b1;
        offer(4'h7); tick(); expect_out("sat_clr", 3'b111, 2'd1);
        check_eq("sat.clr_acc", 32'(sat_count), 32'd1);
        sat_clear = 1'b0;
        offer(4'h5); tick();
        check_eq("sat.main2",  32'(sat_count),  32'd2);
        check_eq("sat.small2", 32'(sat_count2), 32'd2);
        tick();
        check_eq("sat.main3",  32'(sat_count),  32'd3);
        check_eq("sat.small3", 32'(sat_count2), 32'd3);
        tick();
        check_eq("sat.main4",  32'(sat_count),  32'd4);
        check_eq("sat.stick",  32'(sat_count2), 32'd3);

        // ---------------- fixed thermometer ----------------
        dwa_en = 1'b0;
        offer(4'h0); tick(); expect_out("thm1", 3'b001, 2'd0);
        offer(4'h1); tick(); expect_out("thm2", 3'b011, 2'd0);
        offer(4'h2); tick(); expect_out("thm3", 3'b111, 2'd0);
        check_eq("thm.sat", 32'(sat_count), 32'd4);
        dwa_en = 1'b1;
        offer(4'h0); tick(); expect_out("redwa", 3'b001, 2'd1);

        // ---------------- backpressure ----------------
        m_if.tready = 1'b0;
        #1;
        check_eq("bp.s_ready", 32'(s_if.tready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("bp%0d", i), 3'b001, 2'd1);
            check_eq($sformatf("bp%0d.s_ready", i), 32'(s_if.tready), 32'd0);
        end
        m_if.tready = 1'b1;
        #1;
        check_eq("bp.release", 32'(s_if.tready), 32'd1);
        tick();              expect_out("bp.next",  3'b010, 2'd2);
        offer(4'h1); tick(); expect_out("bp.next2", 3'b101, 2'd1);

        // ---------------- idle drains output, ptr holds ----------------
        s_if.tvalid = 1'b0;
        tick();
        check_eq("idle.valid", 32'(m_if.tvalid), 32'd0);
        check_eq("idle.ptr",   32'(ptr),         32'd1);

        // ---------------- reset while stalled ----------------
        offer(4'h0); tick(); expect_out("pre_rst", 3'b010, 2'd2);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        tick();      expect_out("stall", 3'b010, 2'd2);
        arst_n = 1'b0;
        #1;
        check_eq("mrst.s_ready", 32'(s_if.tready), 32'd0);
        tick();
        check_eq("mrst.valid", 32'(m_if.tvalid), 32'd0);
        check_eq("mrst.ptr",   32'(ptr),         32'd0);
        check_eq("mrst.sat",   32'(sat_count),   32'd0);
        arst_n      = 1'b1;
        m_if.tready = 1'b1;
        offer(4'h0); tick(); expect_out("post_rst", 3'b001, 2'd1);
        s_if.tvalid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
